// File: rtl/memory_access.sv
// Memory stage: blocking data-memory handshake, pipeline stall and writeback registers.
// Define MEM_TIMEOUT_EN to abort unanswered requests and raise a sticky bus_error_o.
`timescale 1ns/1ps
module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_write_m_i,
  input  logic        mem_write_m_i,
  input  logic        mem_to_reg_m_i,
  input  logic [31:0] alu_out_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [4:0]  write_reg_m_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        reg_write_w_o,
  output logic        mem_to_reg_w_o,
  output logic [31:0] read_data_w_o,
  output logic [31:0] alu_out_w_o,
  output logic [4:0]  write_reg_w_o,
  output logic        bus_error_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic   access;
  logic   in_wait;
  logic   ack;
  logic   timeout;
  logic   stall;

  assign access  = mem_write_m_i | mem_to_reg_m_i;
  assign in_wait = (state_q == WAIT);
  assign ack     = in_wait & mem_ack_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          berr_q;

  // an ack in the final cycle beats the timeout
  assign timeout = in_wait & ~mem_ack_i
                 & (cnt_q == T_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (in_wait & ~mem_ack_i & ~timeout) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      berr_q <= 1'b0;
    end else if (timeout) begin
      berr_q <= 1'b1;
    end
  end

  assign bus_error_o = berr_q;
`else
  assign timeout     = 1'b0 & (TIMEOUT_CYCLES > 0);
  assign bus_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access) state_d = WAIT;
      WAIT: if (ack | timeout) state_d = IDLE;
    endcase
  end

  // reset also masks the request so a dropped WAIT is visible at once
  assign stall = rst_i
               & ((~in_wait & access)
               |  (in_wait & ~mem_ack_i & ~timeout));

  assign stall_o     = stall;
  assign mem_req_o   = rst_i & (in_wait | access);
  assign mem_we_o    = rst_i & mem_write_m_i;
  assign mem_addr_o  = {32{rst_i}} & alu_out_m_i;
  assign mem_wdata_o = {32{rst_i}} & write_data_m_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_w_o  <= 1'b0;
      mem_to_reg_w_o <= 1'b0;
      alu_out_w_o    <= '0;
      write_reg_w_o  <= '0;
      read_data_w_o  <= '0;
    end else if (!stall) begin
      reg_write_w_o  <= reg_write_m_i & ~timeout;
      mem_to_reg_w_o <= mem_to_reg_m_i;
      alu_out_w_o    <= alu_out_m_i;
      write_reg_w_o  <= write_reg_m_i;
      if (timeout) begin
        read_data_w_o <= '0;
      end else if (ack) begin
        read_data_w_o <= mem_rdata_i;
      end
    end
  end

endmodule
